// File: rtl/cp0_tlb_seq_if.sv
// Request handshake between the MEM stage and the CP0 TLB instruction sequencer.
interface cp0_tlb_seq_if;
    logic       req_valid;
    logic [1:0] req_op;
    logic       req_ready;

    modport master (output req_valid, output req_op, input  req_ready);
    modport slave  (input  req_valid, input  req_op, output req_ready);
endinterface

// File: rtl/cp0_tlb_seq.sv
// Sequences TLBP/TLBR/TLBWI/TLBWR through probe lookup, CP0 commit strobe and retire,
// stalling the front end while an operation is in flight.
module cp0_tlb_seq #(
    parameter int TLB_ENTRIES = 16,
    parameter int LOOKUP_LAT  = 1,
    localparam int IW = (TLB_ENTRIES > 1) ? $clog2(TLB_ENTRIES) : 1
) (
    input  logic                clk,
    input  logic                reset,
    cp0_tlb_seq_if.slave        req_if,
    input  logic                flush,
    output logic                tlbp_req,
    input  logic                tlbp_hit,
    input  logic [IW-1:0]       tlbp_idx,
    output logic [3:0]          tlb_op,
    output logic [31:0]         tlbp_index,
    output logic                stall,
    output logic                done,
    output logic                refetch
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOOKUP = 3'd1;
    localparam logic [2:0] ST_WAIT   = 3'd2;
    localparam logic [2:0] ST_COMMIT = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    localparam logic [1:0] OP_TLBP  = 2'd0;
    localparam logic [1:0] OP_TLBR  = 2'd1;
    localparam logic [1:0] OP_TLBWI = 2'd2;
    localparam logic [1:0] OP_TLBWR = 2'd3;

    localparam logic [2:0] CNT_LOAD = 3'(LOOKUP_LAT - 1);

    logic [2:0]    state_r;
    logic [2:0]    state_nxt_s;
    logic [2:0]    cnt_r;
    logic [1:0]    op_r;
    logic          hit_r;
    logic [IW-1:0] idx_r;
    logic          ready_s;
    logic          accept_s;
    logic [3:0]    tlb_op_s;

    assign ready_s        = !reset && (state_r == ST_IDLE) && !flush;
    assign accept_s       = req_if.req_valid && ready_s;
    assign req_if.req_ready = ready_s;

    // Next-state decode; a flush only aborts before the commit point.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (req_if.req_op == OP_TLBP) begin
                        state_nxt_s = ST_LOOKUP;
                    end else begin
                        state_nxt_s = ST_COMMIT;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOOKUP: begin
                if (flush) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (flush) begin
                    state_nxt_s = ST_IDLE;
                end else if (cnt_r == 3'd0) begin
                    state_nxt_s = ST_COMMIT;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_COMMIT: state_nxt_s = ST_DONE;
            ST_DONE:   state_nxt_s = ST_IDLE;
            default:   state_nxt_s = ST_IDLE;
        endcase
    end

    // State, latency counter, opcode and probe-result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= 3'd0;
            op_r    <= 2'd0;
            hit_r   <= 1'b0;
            idx_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            if (accept_s) begin
                op_r <= req_if.req_op;
            end
            if (state_r == ST_LOOKUP) begin
                cnt_r <= CNT_LOAD;
            end else if ((state_r == ST_WAIT) && (cnt_r != 3'd0)) begin
                cnt_r <= cnt_r - 3'd1;
            end
            // The probe result is only trusted on the sampling cycle of WAIT.
            if ((state_r == ST_WAIT) && (cnt_r == 3'd0) && !flush) begin
                hit_r <= tlbp_hit;
                idx_r <= tlbp_idx;
            end
        end
    end

    // One-hot commit strobe selected by the registered opcode.
    always_comb begin
        tlb_op_s = 4'b0000;
        if (!reset && (state_r == ST_COMMIT)) begin
            case (op_r)
                OP_TLBP:  tlb_op_s = 4'b0001;
                OP_TLBR:  tlb_op_s = 4'b0010;
                OP_TLBWI: tlb_op_s = 4'b0100;
                OP_TLBWR: tlb_op_s = 4'b1000;
                default:  tlb_op_s = 4'b0000;
            endcase
        end else begin
            tlb_op_s = 4'b0000;
        end
    end

    // Index register value: probe-failure bit on a miss, matched entry on a hit.
    always_comb begin
        tlbp_index = 32'h0000_0000;
        if (tlb_op_s[0]) begin
            if (hit_r) begin
                tlbp_index = {{(32-IW){1'b0}}, idx_r};
            end else begin
                tlbp_index = 32'h8000_0000;
            end
        end else begin
            tlbp_index = 32'h0000_0000;
        end
    end

    assign tlb_op   = tlb_op_s;
    assign tlbp_req = !reset && (state_r == ST_LOOKUP);
    assign stall    = !reset && ((state_r != ST_IDLE) || accept_s);
    assign done     = !reset && (state_r == ST_DONE);
    assign refetch  = done && op_r[1];

endmodule
